// File: rtl/decoder_proj_seq_if.sv
// decoder_proj_seq_if: groups the pad input and decoded outputs of decoder_proj_seq.
//
// Signals:
//   io_in      pad vector: [CODE_W-1:0] code, [CODE_W] en, [CODE_W+1] clr, [CODE_W+2] parity
//   dec_out    latched one-hot decode of the last accepted code (2**CODE_W bits)
//   dec_valid  one-cycle pulse per accept
//   err        sticky parity error
//   hit_cnt    saturating count of good accepts
//   state_o    FSM state encoding for observability
//
// Modports: slave (the decoder), master (whatever drives the pads and consumes the outputs).
interface decoder_proj_seq_if #(
    parameter int unsigned IN_W   = 7,
    parameter int unsigned CODE_W = 4,
    parameter int unsigned CNT_W  = 8
);
    logic [IN_W-1:0]        io_in;
    logic [(2**CODE_W)-1:0] dec_out;
    logic                   dec_valid;
    logic                   err;
    logic [CNT_W-1:0]       hit_cnt;
    logic [1:0]             state_o;

    modport slave (
        input  io_in,
        output dec_out,
        output dec_valid,
        output err,
        output hit_cnt,
        output state_o
    );

    modport master (
        output io_in,
        input  dec_out,
        input  dec_valid,
        input  err,
        input  hit_cnt,
        input  state_o
    );
endinterface

// File: rtl/decoder_proj_seq.sv
// decoder_proj_seq: sequential one-hot code decoder behind the user-project io_in pads.
//
// io_in is double-flop synchronised, filtered until it has been stable for STABLE_CYC
// samples, then accepted exactly once per stable vector. A good accept latches a one-hot
// decode, pulses dec_valid and bumps a saturating hit counter; a bad-parity accept pulses
// dec_valid and sets a sticky error instead. A synchronised clr bit clears the results.
//
// Ports:
//   clock  single system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    decoder_proj_seq_if.slave (io_in in; dec_out, dec_valid, err, hit_cnt, state_o out)
//
// Optional feature macro: DECODER_PROJ_PARITY_EN
//   defined   -> parity bit is checked; a mismatch sets err and suppresses the decode
//   undefined -> parity bit is ignored, every accept is good, err is tied 0
module decoder_proj_seq #(
    parameter int unsigned IN_W       = 7,
    parameter int unsigned CODE_W     = 4,
    parameter int unsigned STABLE_CYC = 3,
    parameter int unsigned CNT_W      = 8
) (
    input logic              clock,
    input logic              reset,
    decoder_proj_seq_if.slave bus
);

    localparam int unsigned DEC_W  = 2**CODE_W;
    localparam int unsigned STAB_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSettle = 2'b01,
        StAccept = 2'b10,
        StHold   = 2'b11
    } state_e;

    logic [IN_W-1:0]   sync1_q, sync2_q, prev_q;
    logic [STAB_W-1:0] stab_q, stab_d;
    state_e            state_q, state_d;
    logic [DEC_W-1:0]  dec_q, dec_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  hit_q, hit_d;

    logic              changed;
    logic              en;
    logic              clr;
    logic [CODE_W-1:0] acc_code;
    logic              par_ok;

    assign changed = (sync2_q != prev_q);
    assign en      = sync2_q[CODE_W];
    assign clr     = sync2_q[CODE_W+1];

    // In the ACCEPT cycle prev_q still holds the vector that passed the stability filter,
    // so the accept uses it even if a new value is just arriving in sync2_q.
    assign acc_code = prev_q[CODE_W-1:0];

`ifdef DECODER_PROJ_PARITY_EN
    logic err_q, err_d;
    // Even parity over code plus parity bit.
    assign par_ok  = (prev_q[CODE_W+2] == ^acc_code);
    assign bus.err = err_q;
`else
    assign par_ok  = 1'b1;
    assign bus.err = 1'b0;
`endif

    // Stability counter: restarts on any change, saturates at STABLE_CYC-1.
    always_comb begin
        stab_d = stab_q;
        if (changed) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + STAB_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        valid_d = 1'b0;
        hit_d   = hit_q;
`ifdef DECODER_PROJ_PARITY_EN
        err_d   = err_q;
`endif
        if (clr) begin
            // Level-sensitive clear wins over any accept in the same cycle.
            state_d = StIdle;
            dec_d   = '0;
            hit_d   = '0;
`ifdef DECODER_PROJ_PARITY_EN
            err_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en && !changed) begin
                        state_d = StSettle;
                    end
                end
                StSettle: begin
                    if (changed || !en) begin
                        state_d = StIdle;
                    end else if (stab_q == STAB_MAX) begin
                        state_d = StAccept;
                    end
                end
                StAccept: begin
                    valid_d = 1'b1;
                    if (par_ok) begin
                        dec_d           = '0;
                        dec_d[acc_code] = 1'b1;
                        if (hit_q != '1) begin
                            hit_d = hit_q + CNT_W'(1);
                        end
                    end else begin
`ifdef DECODER_PROJ_PARITY_EN
                        err_d = 1'b1;
`endif
                    end
                    // A change landing during the accept cycle must still re-arm.
                    state_d = changed ? StIdle : StHold;
                end
                StHold: begin
                    if (changed) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            stab_q  <= '0;
            state_q <= StIdle;
            dec_q   <= '0;
            valid_q <= 1'b0;
            hit_q   <= '0;
`ifdef DECODER_PROJ_PARITY_EN
            err_q   <= 1'b0;
`endif
        end else begin
            sync1_q <= bus.io_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            stab_q  <= stab_d;
            state_q <= state_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
`ifdef DECODER_PROJ_PARITY_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.dec_out   = dec_q;
    assign bus.dec_valid = valid_q;
    assign bus.hit_cnt   = hit_q;
    assign bus.state_o   = state_q;

endmodule
